// File: rtl/control_sequencer.sv
// Hardwired control unit for the DataPath: fetches, decodes IR[31:27] and
// sequences the per-opcode T-states, waiting on ALU and memory handshakes.
module control_sequencer #(
    parameter logic [5:0] ALU_ADD     = 6'b000100,
    parameter logic [5:0] ALU_SUB     = 6'b000101,
    parameter logic [5:0] ALU_AND     = 6'b000110,
    parameter logic [5:0] ALU_OR      = 6'b000111,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        finished,
    input  logic        memFinished,
    output logic        PCout,
    output logic        RZLOout,
    output logic        MDRout,
    output logic        Immout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        IRin,
    output logic        RYin,
    output logic        RZin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        start,
    output logic [5:0]  opSelect,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [3:0] {
        S_RST, S_F0, S_F1, S_F2, S_DEC, S_A3, S_A4, S_AW,
        S_A5, S_M5, S_M6, S_M7, S_S6, S_S7, S_HALT, S_FAULT
    } state_t;

    // Instruction class latched at decode so the shared A3..A5 states stay Moore.
    typedef enum logic [2:0] {K_RR, K_IMM, K_LD, K_LDI, K_ST} kind_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    kind_t       kind_reg, kind_next;
    logic [5:0]  op_reg, op_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [4:0]  opcode;
    logic        timed_out;
    logic        ir_unused;

    assign opcode    = IR[31:27];
    assign timed_out = (wait_cnt_reg == WAIT_LAST);
    assign ir_unused = ^IR[26:0];

    always_ff @(posedge Clock) begin
        if (clear) begin
            state_reg    <= S_RST;
            kind_reg     <= K_RR;
            op_reg       <= 6'd0;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            kind_reg     <= kind_next;
            op_reg       <= op_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        kind_next     = kind_reg;
        op_next       = op_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            S_RST: state_next = S_F0;
            S_F0: begin
                state_next    = S_F1;
                wait_cnt_next = 8'd0;
            end
            S_F1: begin
                if (memFinished)    state_next = S_F2;
                else if (timed_out) state_next = S_FAULT;
                else                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
            S_F2: state_next = S_DEC;
            S_DEC: begin
                state_next = S_A3;
                op_next    = ALU_ADD;
                case (opcode)
                    5'b00000: kind_next = K_LD;
                    5'b00001: kind_next = K_LDI;
                    5'b00010: kind_next = K_ST;
                    5'b00011: kind_next = K_RR;
                    5'b00100: begin kind_next = K_RR;  op_next = ALU_SUB; end
                    5'b00101: begin kind_next = K_RR;  op_next = ALU_AND; end
                    5'b00110: begin kind_next = K_RR;  op_next = ALU_OR;  end
                    5'b01100: kind_next = K_IMM;
                    5'b01101: begin kind_next = K_IMM; op_next = ALU_AND; end
                    5'b01110: begin kind_next = K_IMM; op_next = ALU_OR;  end
                    5'b11011: state_next = S_HALT;
                    default:  state_next = S_F0;
                endcase
            end
            S_A3: state_next = S_A4;
            S_A4: state_next = S_AW;
            S_AW: begin
                if (finished)
                    state_next = (kind_reg == K_LD || kind_reg == K_ST) ? S_M5 : S_A5;
            end
            S_A5: state_next = S_F0;
            S_M5: begin
                state_next    = (kind_reg == K_ST) ? S_S6 : S_M6;
                wait_cnt_next = 8'd0;
            end
            S_M6: begin
                if (memFinished)    state_next = S_M7;
                else if (timed_out) state_next = S_FAULT;
                else                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
            S_M7: state_next = S_F0;
            S_S6: begin
                state_next    = S_S7;
                wait_cnt_next = 8'd0;
            end
            S_S7: begin
                if (memFinished)    state_next = S_F0;
                else if (timed_out) state_next = S_FAULT;
                else                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
            S_HALT:  state_next = S_HALT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_RST;
        endcase
    end

    always_comb begin
        PCout = 1'b0; RZLOout = 1'b0; MDRout = 1'b0; Immout = 1'b0;
        BAout = 1'b0; Rout = 1'b0; PCin = 1'b0; IRin = 1'b0;
        RYin = 1'b0; RZin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        Rin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0; start = 1'b0;
        opSelect = 6'd0; halted = 1'b0; fault = 1'b0;
        case (state_reg)
            S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_F1: begin Read = 1'b1; MDRin = 1'b1; end
            S_F2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_A3: begin
                Grb   = 1'b1;
                Rout  = 1'b1;
                RYin  = 1'b1;
                BAout = (kind_reg != K_RR) && (kind_reg != K_IMM);
            end
            S_A4, S_AW: begin
                RZin     = 1'b1;
                opSelect = op_reg;
                start    = (state_reg == S_A4);
                if (kind_reg == K_RR) begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                end else begin
                    Immout = 1'b1;
                end
            end
            S_A5:    begin RZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_M5:    begin RZLOout = 1'b1; MARin = 1'b1; end
            S_M6:    begin Read = 1'b1; MDRin = 1'b1; end
            S_M7:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_S6:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            S_S7:    begin Write = 1'b1; Gra = 1'b1; Rout = 1'b1; end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class cycle by
// cycle and compares every output against hand-built per-state vectors.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'd0;
    logic        finished = 1'b0;
    logic        memFinished = 1'b0;
    logic PCout, RZLOout, MDRout, Immout, BAout, Rout, PCin, IRin, RYin, RZin;
    logic MARin, MDRin, Rin, Gra, Grb, Grc, IncPC, Read, Write, start;
    logic halted, fault;
    logic [5:0] opSelect;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .Clock(clk), .clear(clear), .IR(IR), .finished(finished),
        .memFinished(memFinished), .PCout(PCout), .RZLOout(RZLOout),
        .MDRout(MDRout), .Immout(Immout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .MDRin(MDRin), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .IncPC(IncPC), .Read(Read), .Write(Write), .start(start),
        .opSelect(opSelect), .halted(halted), .fault(fault)
    );

    localparam logic [21:0] PCOUT = 22'd1 << 21, RZLOOUT = 22'd1 << 20,
        MDROUT = 22'd1 << 19, IMMOUT = 22'd1 << 18, BAOUT = 22'd1 << 17,
        ROUT = 22'd1 << 16, IRIN = 22'd1 << 14, RYIN = 22'd1 << 13,
        RZIN = 22'd1 << 12, MARIN = 22'd1 << 11, MDRIN = 22'd1 << 10,
        RIN = 22'd1 << 9, GRA = 22'd1 << 8, GRB = 22'd1 << 7, GRC = 22'd1 << 6,
        INCPC = 22'd1 << 5, READ = 22'd1 << 4, WRITE = 22'd1 << 3,
        START = 22'd1 << 2, HALTED = 22'd1 << 1, FAULTB = 22'd1;

    localparam logic [21:0] E_RST = 22'd0, E_F0 = PCOUT | MARIN | INCPC,
        E_F1 = READ | MDRIN, E_F2 = MDROUT | IRIN, E_D = 22'd0,
        E_A3R = GRB | ROUT | RYIN, E_A3M = GRB | BAOUT | ROUT | RYIN,
        E_A4R = GRC | ROUT | RZIN | START, E_AWR = GRC | ROUT | RZIN,
        E_A4I = IMMOUT | RZIN | START, E_AWI = IMMOUT | RZIN,
        E_A5 = RZLOOUT | GRA | RIN, E_M5 = RZLOOUT | MARIN, E_M6 = READ | MDRIN,
        E_M7 = MDROUT | GRA | RIN, E_S6 = GRA | ROUT | MDRIN,
        E_S7 = WRITE | GRA | ROUT, E_HALT = HALTED, E_FAULT = FAULTB;

    function automatic logic [27:0] obs();
        return {PCout, RZLOout, MDRout, Immout, BAout, Rout, PCin, IRin, RYin,
                RZin, MARin, MDRin, Rin, Gra, Grb, Grc, IncPC, Read, Write,
                start, halted, fault, opSelect};
    endfunction

    // Leaves the bench at a falling edge with the DUT in RST; next edge enters F0.
    task automatic do_reset();
        @(negedge clk);
        clear = 1'b1; memFinished = 1'b0; finished = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        IR = 32'h19888000;
        do_reset();
        checks++;
        if (obs() !== {E_RST, 6'd0}) begin
            errors++; $display("FAIL reset_initial: got %h want %h", obs(), {E_RST, 6'd0});
        end
        @(negedge clk);
        checks++;
        if (obs() !== {E_F0, 6'd0}) begin
            errors++; $display("FAIL reset_f0: got %h want %h", obs(), {E_F0, 6'd0});
        end
        @(negedge clk);
        checks++;
        if (obs() !== {E_F1, 6'd0}) begin
            errors++; $display("FAIL reset_f1_read: got %h want %h", obs(), {E_F1, 6'd0});
        end
        clear = 1'b1; memFinished = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {E_RST, 6'd0}) begin
                errors++; $display("FAIL reset_hold[%0d]: got %h want %h", i, obs(), {E_RST, 6'd0});
            end
        end
        clear = 1'b0; memFinished = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== {E_F0, 6'd0}) begin
            errors++; $display("FAIL reset_release_f0: got %h want %h", obs(), {E_F0, 6'd0});
        end
        $display("reset: clear mid-F1 -> RST x2 -> F0");
    endtask

    task automatic test_add();
        logic [21:0] e [11] = '{E_F0, E_F1, E_F1, E_F2, E_D, E_A3R, E_A4R, E_AWR, E_AWR, E_A5, E_F0};
        logic [5:0]  o [11] = '{0, 0, 0, 0, 0, 0, 4, 4, 4, 0, 0};
        logic        m [11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        logic        f [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        IR = 32'h19888000;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {e[i], o[i]}) begin
                errors++; $display("FAIL add step %0d: got %h want %h", i, obs(), {e[i], o[i]});
            end
            memFinished = m[i]; finished = f[i];
        end
        $display("add R3,R1,R2: 11 cycles checked");
    endtask

    task automatic test_st();
        logic [21:0] e [13] = '{E_F0, E_F1, E_F2, E_D, E_A3M, E_A4I, E_AWI, E_M5, E_S6, E_S7, E_S7, E_S7, E_F0};
        logic [5:0]  o [13] = '{0, 0, 0, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0};
        logic        m [13] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        logic        f [13] = '{0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
        IR = 32'h1108001F;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {e[i], o[i]}) begin
                errors++; $display("FAIL st step %0d: got %h want %h", i, obs(), {e[i], o[i]});
            end
            memFinished = m[i]; finished = f[i];
        end
        $display("st 0x1F(R1),R2: 13 cycles checked");
    endtask

    task automatic test_ld();
        logic [21:0] e [15] = '{E_F0, E_F1, E_F2, E_D, E_A3M, E_A4I, E_AWI, E_M5,
                                E_M6, E_M6, E_M6, E_M6, E_M6, E_M7, E_F0};
        logic [5:0]  o [15] = '{0, 0, 0, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        logic        m [15] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic        f [15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        IR = 32'h02000010;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {e[i], o[i]}) begin
                errors++; $display("FAIL ld step %0d: got %h want %h", i, obs(), {e[i], o[i]});
            end
            memFinished = m[i]; finished = f[i];
        end
        $display("ld R4,0x10(R0): 15 cycles checked");
    endtask

    task automatic test_ldi();
        logic [21:0] e [9] = '{E_F0, E_F1, E_F2, E_D, E_A3M, E_A4I, E_AWI, E_A5, E_F0};
        logic [5:0]  o [9] = '{0, 0, 0, 0, 0, 4, 4, 0, 0};
        logic        m [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        logic        f [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        IR = 32'h08800005;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {e[i], o[i]}) begin
                errors++; $display("FAIL ldi step %0d: got %h want %h", i, obs(), {e[i], o[i]});
            end
            memFinished = m[i]; finished = f[i];
        end
        $display("ldi R1,5: 9 cycles checked");
    endtask

    task automatic test_back_to_back();
        logic [21:0] e [17] = '{E_F0, E_F1, E_F2, E_D, E_A3R, E_A4I, E_AWI, E_A5,
                                E_F0, E_F1, E_F2, E_D, E_A3R, E_A4R, E_AWR, E_A5, E_F0};
        logic [5:0]  o [17] = '{0, 0, 0, 0, 0, 6, 6, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0};
        logic        m [17] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        logic        f [17] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        IR = 32'h68880003;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {e[i], o[i]}) begin
                errors++; $display("FAIL b2b step %0d: got %h want %h", i, obs(), {e[i], o[i]});
            end
            memFinished = m[i]; finished = f[i];
            if (i == 8) IR = 32'h20888000;
        end
        $display("andi then sub back to back: 17 cycles checked");
    endtask

    task automatic test_halt();
        logic [21:0] e [4] = '{E_F0, E_F1, E_F2, E_D};
        logic        m [4] = '{0, 1, 0, 0};
        IR = 32'hD8000000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {e[i], 6'd0}) begin
                errors++; $display("FAIL halt_fetch step %0d: got %h want %h", i, obs(), {e[i], 6'd0});
            end
            memFinished = m[i];
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {E_HALT, 6'd0}) begin
                errors++; $display("FAIL halt_sticky[%0d]: got %h want %h", i, obs(), {E_HALT, 6'd0});
            end
            memFinished = i[0]; finished = ~i[0];
        end
        clear = 1'b1; memFinished = 1'b0; finished = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== {E_RST, 6'd0}) begin
            errors++; $display("FAIL halt_clear_rst: got %h want %h", obs(), {E_RST, 6'd0});
        end
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== {E_F0, 6'd0}) begin
            errors++; $display("FAIL halt_clear_f0: got %h want %h", obs(), {E_F0, 6'd0});
        end
        $display("halt: 20 sticky cycles, clear -> RST -> F0");
    endtask

    task automatic test_fault_and_nop();
        logic [21:0] e [5] = '{E_F0, E_F1, E_F2, E_D, E_F0};
        logic        m [5] = '{0, 1, 0, 0, 0};
        IR = 32'h19888000;
        do_reset();
        @(negedge clk);
        checks++;
        if (obs() !== {E_F0, 6'd0}) begin
            errors++; $display("FAIL fault_f0: got %h want %h", obs(), {E_F0, 6'd0});
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {E_F1, 6'd0}) begin
                errors++; $display("FAIL fault_wait[%0d]: got %h want %h", i, obs(), {E_F1, 6'd0});
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {E_FAULT, 6'd0}) begin
                errors++; $display("FAIL fault_sticky[%0d]: got %h want %h", i, obs(), {E_FAULT, 6'd0});
            end
            memFinished = 1'b1;
        end
        IR = 32'hF8000000;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== {e[i], 6'd0}) begin
                errors++; $display("FAIL nop11111 step %0d: got %h want %h", i, obs(), {e[i], 6'd0});
            end
            memFinished = m[i];
        end
        $display("watchdog: FAULT after 16 F1 cycles; opcode 11111 as nop");
    endtask

    initial begin
        test_reset();
        test_add();
        test_st();
        test_ld();
        test_ldi();
        test_back_to_back();
        test_halt();
        test_fault_and_nop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the DataPath control inputs. It replaces the hand-sequenced T-state stimulus currently written per instruction in the phase-2 benches.
- Fetches each instruction, decodes IR[31:27] and steps through the T-state sequence for that opcode.
- Waits on the ALU `finished` and memory `memFinished` handshakes before advancing.
- Sits directly upstream of DataPath. Its outputs connect one-to-one to the same-named DataPath ports.

Parameters:
- ALU_ADD, 6'b000100, opSelect code for add; also used for address and immediate computation.
- ALU_SUB, 6'b000101, opSelect code for sub.
- ALU_AND, 6'b000110, opSelect code for and/andi.
- ALU_OR, 6'b000111, opSelect code for or/ori.
- MEM_TIMEOUT, 16, maximum cycles to wait for memFinished before entering FAULT.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- IR  in  32  instruction register contents from DataPath; opcode is IR[31:27].
- finished  in  1  ALU done.
- memFinished  in  1  memory access done.
- PCout, RZLOout, MDRout, Immout, BAout, Rout  out  1 each  bus drive selects.
- PCin, IRin, RYin, RZin, MARin, MDRin, Rin  out  1 each  register write enables.
- Gra, Grb, Grc  out  1 each  register-field selects.
- IncPC, Read, Write, start  out  1 each  PC increment, memory read/write, ALU start.
- opSelect  out  6  ALU operation.
- halted  out  1  high while in HALT.
- fault  out  1  high while in FAULT.

Behaviour:
- Clock and reset: single clock domain (Clock); clear is synchronous and active-high.
- Output style: Moore. Every output is decoded from the state register only.
- Unlisted outputs are 0 in every state. opSelect is 0 unless stated.
- Reset:
  - clear=1 at a rising edge forces state RST, regardless of state or pending handshake.
  - In RST all outputs are 0, including Read, Write and start. The next edge with clear=0 enters F0.
- Opcodes:
  - ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110.
  - addi 01100, andi 01101, ori 01110, nop 11010, halt 11011.
  - Any other opcode is treated as nop.
- Fetch:
  - F0: PCout, MARin, IncPC.
  - F1: Read, MDRin. Held until memFinished=1 is sampled; then go to F2.
  - F2: MDRout, IRin.
  - D (decode, IR now valid): all outputs 0. Branch on opcode.
- Register/register ALU (add/sub/and/or):
  - A3: Grb, Rout, RYin.
  - A4: Grc, Rout, RZin, opSelect set, start. Next cycle goes to AW.
  - AW: Grc, Rout, RZin and opSelect held, start=0. Wait for finished=1.
  - A5: RZLOout, Gra, Rin. Then F0.
- Immediate ALU (addi/andi/ori): same sequence as register/register, with Immout replacing Grc/Rout in A4 and AW.
- Address calculation (ld/ldi/st):
  - A3 uses Grb, BAout, Rout, RYin, so R0 reads as 0.
  - A4/AW use Immout with opSelect=ALU_ADD.
- ldi: A5 is RZLOout, Gra, Rin. Then F0.
- ld:
  - M5: RZLOout, MARin.
  - M6: Read, MDRin. Wait for memFinished.
  - M7: MDRout, Gra, Rin. Then F0.
- st:
  - M5: RZLOout, MARin.
  - S6: Gra, Rout, MDRin with Read=0, so MDR loads from the bus.
  - S7: Write, Gra, Rout. Held until memFinished. Then F0.
- Control flow:
  - nop and unsupported opcodes: D then F0.
  - halt: D then HALT. HALT is sticky, all strobes are 0, halted=1, and only clear exits.
- Memory wait watchdog:
  - An 8-bit wait counter resets on entry to F1, M6 or S7 and increments on each waiting cycle.
  - Reaching MEM_TIMEOUT without memFinished enters FAULT: fault=1, all strobes 0, sticky until clear.
- ALU wait has no timeout.
- memFinished or finished arriving in the same cycle the wait state is entered is accepted, so the minimum wait is 1 cycle.
- Spurious handshakes: memFinished/finished asserted outside a wait state are ignored.

Test Plan:
- Reset: clear=1 for 2 cycles mid-F1 with Read=1. Required: the next cycle shows all outputs 0 and state RST; the first cycle after release shows F0 (PCout, MARin, IncPC = 1).
- add R3,R1,R2 (IR=32'h19888000), memFinished after 2 cycles, finished 3 cycles after start. Required:
  - Sequence F0,F1,F1,F2,D,A3,A4,AW,AW,A5.
  - start high exactly 1 cycle.
  - opSelect=6'b000100 through A4/AW.
  - Gra, Rin high only in A5.
- st 0x1F(R1),R2 (IR=32'h1108001F). Required:
  - A3 asserts BAout, Grb.
  - A4 asserts Immout with ALU_ADD.
  - M5 asserts MARin, RZLOout.
  - S6 asserts MDRin with Read=0.
  - S7 holds Write until memFinished, then F0.
- ld R4,0x10(R0), memFinished delayed 5 cycles in M6. Required: Read and MDRin stay high 5 cycles; M7 asserts MDRout, Gra, Rin; Write never asserted.
- halt (IR=32'hD8000000). Required: HALT reached after D; halted=1 for 20 cycles with no strobe activity; clear returns to RST, then F0.
- memFinished held 0 during F1. Required: FAULT entered after 16 cycles with fault=1 and Read dropping to 0; opcode 11111 without timeout goes D then F0 as nop.
